// File: rtl/mem_access_stage_pkg.sv
// Shared MIPS pipeline definitions: datapath widths and MEM-stage FSM encoding.
package mem_access_stage_pkg;
  localparam int WORD_W = 32;
  localparam int REG_W  = 5;

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } state_e;
endpackage

// File: rtl/mem_access_stage_mem_wb.sv
// MEM/WB pipeline register; bubble forces regwrite low so the slot writes nothing back.
module mem_access_stage_mem_wb
  import mem_access_stage_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              bubble,
  input  logic              regwrite_in,
  input  logic              memtoreg_in,
  input  logic [WORD_W-1:0] read_data_in,
  input  logic [WORD_W-1:0] result_in,
  input  logic [REG_W-1:0]  reg_dest_in,
  output logic              regwrite_out,
  output logic              memtoreg_out,
  output logic [WORD_W-1:0] read_data_out,
  output logic [WORD_W-1:0] result_out,
  output logic [REG_W-1:0]  reg_dest_out
);
  logic              regwrite_q, regwrite_d;
  logic              memtoreg_q, memtoreg_d;
  logic [WORD_W-1:0] read_data_q, read_data_d;
  logic [WORD_W-1:0] result_q, result_d;
  logic [REG_W-1:0]  reg_dest_q, reg_dest_d;

  always_comb begin
    regwrite_d  = regwrite_in & ~bubble;
    memtoreg_d  = memtoreg_in;
    read_data_d = read_data_in;
    result_d    = result_in;
    reg_dest_d  = reg_dest_in;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      regwrite_q  <= 1'b0;
      memtoreg_q  <= 1'b0;
      read_data_q <= '0;
      result_q    <= '0;
      reg_dest_q  <= '0;
    end else begin
      regwrite_q  <= regwrite_d;
      memtoreg_q  <= memtoreg_d;
      read_data_q <= read_data_d;
      result_q    <= result_d;
      reg_dest_q  <= reg_dest_d;
    end
  end

  assign regwrite_out  = regwrite_q;
  assign memtoreg_out  = memtoreg_q;
  assign read_data_out = read_data_q;
  assign result_out    = result_q;
  assign reg_dest_out  = reg_dest_q;
endmodule

// File: rtl/mem_access_stage.sv
// MIPS MEM stage: data-memory req/ack FSM with timeout, branch resolve, MEM/WB register.
// Optional alignment check enabled by defining MEM_MISALIGN_CHECK_EN.
module mem_access_stage
  import mem_access_stage_pkg::*;
#(
  parameter int TIMEOUT_CYC = 255,
  parameter int CNT_W       = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              branch_ex_mem,
  input  logic              memRead_ex_mem,
  input  logic              memWrite_ex_mem,
  input  logic              regwrite_ex_mem,
  input  logic              MemtoReg_ex_mem,
  input  logic [WORD_W-1:0] pc_branch_target_ex_mem,
  input  logic [WORD_W-1:0] result_ex_mem,
  input  logic [WORD_W-1:0] B_ex_mem,
  input  logic              zero_flag_ex_mem,
  input  logic [REG_W-1:0]  Reg_dest_op_ex_mem,
  input  logic [WORD_W-1:0] dmem_rdata,
  input  logic              dmem_ack,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [WORD_W-1:0] dmem_addr,
  output logic [WORD_W-1:0] dmem_wdata,
  output logic              stall_mem,
  output logic              pc_src,
  output logic [WORD_W-1:0] pc_branch_target_out,
  output logic              regwrite_mem_wb,
  output logic              MemtoReg_mem_wb,
  output logic [WORD_W-1:0] read_data_mem_wb,
  output logic [WORD_W-1:0] result_mem_wb,
  output logic [REG_W-1:0]  Reg_dest_op_mem_wb,
  output logic              dmem_err,
  output logic              misalign
);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYC - 1);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              req_q, req_d;
  logic              we_q, we_d;
  logic [WORD_W-1:0] addr_q, addr_d;
  logic [WORD_W-1:0] wdata_q, wdata_d;
  logic              err_q, err_d;
  logic              misalign_q, misalign_d;
  logic              memop;
  logic              misaligned;
  logic              wb_bubble;
  logic [WORD_W-1:0] wb_rdata;

  assign memop = memRead_ex_mem | memWrite_ex_mem;

`ifdef MEM_MISALIGN_CHECK_EN
  assign misaligned = memop & (result_ex_mem[1:0] != 2'b00);
`else
  assign misaligned = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    req_d      = req_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    err_d      = err_q;
    misalign_d = 1'b0;
    stall_mem  = 1'b0;
    wb_bubble  = 1'b1;
    wb_rdata   = '0;
    if (state_q == IDLE) begin
      if (misaligned) begin
        misalign_d = 1'b1;
      end else if (memop) begin
        stall_mem = 1'b1;
        state_d   = ACCESS;
        req_d     = 1'b1;
        we_d      = memWrite_ex_mem;
        addr_d    = result_ex_mem;
        wdata_d   = B_ex_mem;
        cnt_d     = '0;
      end else begin
        wb_bubble = 1'b0;
      end
    end else begin
      // Ack is tested first so a completion on the last allowed cycle is not an error.
      if (dmem_ack) begin
        state_d   = IDLE;
        req_d     = 1'b0;
        we_d      = 1'b0;
        wb_bubble = 1'b0;
        wb_rdata  = we_q ? '0 : dmem_rdata;
      end else if (cnt_q == TIMEOUT_LAST) begin
        state_d = IDLE;
        req_d   = 1'b0;
        we_d    = 1'b0;
        err_d   = 1'b1;
      end else begin
        stall_mem = 1'b1;
        cnt_d     = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      req_q      <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      err_q      <= 1'b0;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      req_q      <= req_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      err_q      <= err_d;
      misalign_q <= misalign_d;
    end
  end

  assign dmem_req             = req_q;
  assign dmem_we              = we_q;
  assign dmem_addr            = addr_q;
  assign dmem_wdata           = wdata_q;
  assign dmem_err             = err_q;
  assign misalign             = misalign_q;
  assign pc_src               = branch_ex_mem & zero_flag_ex_mem;
  assign pc_branch_target_out = pc_branch_target_ex_mem;

  mem_access_stage_mem_wb u_mem_wb (
    .clk          (clk),
    .reset        (reset),
    .bubble       (wb_bubble),
    .regwrite_in  (regwrite_ex_mem),
    .memtoreg_in  (MemtoReg_ex_mem),
    .read_data_in (wb_rdata),
    .result_in    (result_ex_mem),
    .reg_dest_in  (Reg_dest_op_ex_mem),
    .regwrite_out (regwrite_mem_wb),
    .memtoreg_out (MemtoReg_mem_wb),
    .read_data_out(read_data_mem_wb),
    .result_out   (result_mem_wb),
    .reg_dest_out (Reg_dest_op_mem_wb)
  );
endmodule
